// File: rtl/screen_ctl_pkg.sv
// ---------------------------------------------------------------------------
// screen_ctl_pkg
// Shared definitions for the memory-game screen sequencer.
//   SCREEN_MENU/GAME/END : codes driven on the screen output
//   SEC_W                : width of the elapsed-seconds counter
//   state_e              : sequencer state, encoded as the screen code
// ---------------------------------------------------------------------------
package screen_ctl_pkg;

  localparam logic [1:0] SCREEN_MENU = 2'd0;
  localparam logic [1:0] SCREEN_GAME = 2'd1;
  localparam logic [1:0] SCREEN_END  = 2'd2;

  localparam int SEC_W = 10;

  // The state encoding is the screen code itself, so screen needs no decode.
  typedef enum logic [1:0] {
    ST_MENU = SCREEN_MENU,
    ST_GAME = SCREEN_GAME,
    ST_END  = SCREEN_END
  } state_e;

endpackage

// File: rtl/screen_ctl_sec_timer.sv
// ---------------------------------------------------------------------------
// sec_timer
// Seconds counter for the in-game score overlay.
//   clk          : clock
//   rst          : synchronous active-high reset
//   run          : count while high, freeze while low
//   clear        : zero prescaler and seconds (wins over run)
//   elapsed_sec  : whole seconds counted, saturating at MAX_SEC
// ---------------------------------------------------------------------------
module sec_timer
  import screen_ctl_pkg::*;
#(
  parameter int CLK_FREQ = 65_000_000,
  parameter int MAX_SEC  = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             clear,
  output logic [SEC_W-1:0] elapsed_sec
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [SEC_W-1:0] SEC_LAST   = SEC_W'(MAX_SEC);

  logic [PW-1:0]    presc_q, presc_d;
  logic [SEC_W-1:0] sec_q,   sec_d;

  // Prescaler divides the clock down to one tick per second; the seconds
  // counter advances on that tick and sticks at its ceiling.
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    if (clear) begin
      presc_d = '0;
      sec_d   = '0;
    end else if (run) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (sec_q != SEC_LAST) begin
          sec_d = sec_q + SEC_W'(1);
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
    end
  end

  assign elapsed_sec = sec_q;

endmodule

// File: rtl/screen_ctl.sv
// ---------------------------------------------------------------------------
// screen_ctl
// Screen sequencer for the memory game: MENU -> GAME -> END -> GAME ...
//   clk, rst       : clock, synchronous active-high reset
//   mouse_left     : synchronised left-button level
//   start_pressed  : strobe from the Start button
//   again_pressed  : strobe from the Play-again button
//   board_done     : all pairs matched
//   menu_enable    : enable for the Start button
//   board_enable   : enable for the card board
//   end_enable     : enable for the Play-again button
//   new_game       : one-cycle pulse, board reshuffles
//   screen         : current screen code
//   elapsed_sec    : seconds spent in GAME, saturating
// ---------------------------------------------------------------------------
module screen_ctl
  import screen_ctl_pkg::*;
#(
  parameter int CLK_FREQ       = 65_000_000,
  parameter int HOLDOFF_CYCLES = 1_000_000,
  parameter int MAX_SEC        = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mouse_left,
  input  logic             start_pressed,
  input  logic             again_pressed,
  input  logic             board_done,
  output logic             menu_enable,
  output logic             board_enable,
  output logic             end_enable,
  output logic             new_game,
  output logic [1:0]       screen,
  output logic [SEC_W-1:0] elapsed_sec
);

  localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF_CYCLES);

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [HW-1:0] hold_q,  hold_d;
  logic          new_game_q, new_game_d;
  logic          changing;

  // Next-state logic. Strobes only count when the screen is armed; in GAME
  // the board completion is checked alone, so it wins over any strobe.
  always_comb begin
    state_d    = state_q;
    new_game_d = 1'b0;
    case (state_q)
      ST_MENU: begin
        if (armed_q && start_pressed) begin
          state_d    = ST_GAME;
          new_game_d = 1'b1;
        end
      end
      ST_GAME: begin
        if (board_done) begin
          state_d = ST_END;
        end
      end
      ST_END: begin
        if (armed_q && again_pressed) begin
          state_d    = ST_GAME;
          new_game_d = 1'b1;
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  // Holdoff and arming. Every screen change disarms and restarts the holdoff,
  // and arming additionally waits for the mouse to be released, so the click
  // that caused a change can never fire a button on the new screen.
  always_comb begin
    changing = (state_d != state_q);
    hold_d   = hold_q;
    armed_d  = armed_q;
    if (changing) begin
      hold_d  = HOLD_LOAD;
      armed_d = 1'b0;
    end else begin
      if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end
      if ((hold_q == '0) && !mouse_left) begin
        armed_d = 1'b1;
      end
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_MENU;
      armed_q    <= 1'b0;
      hold_q     <= HOLD_LOAD;
      new_game_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      hold_q     <= hold_d;
      new_game_q <= new_game_d;
    end
  end

  // The timer is cleared on the same edge that raises new_game, so the
  // overlay shows zero together with the pulse.
  sec_timer #(
    .CLK_FREQ (CLK_FREQ),
    .MAX_SEC  (MAX_SEC)
  ) u_sec_timer (
    .clk         (clk),
    .rst         (rst),
    .run         (state_q == ST_GAME),
    .clear       (new_game_d),
    .elapsed_sec (elapsed_sec)
  );

  // Outputs come only from registers.
  assign screen       = state_q;
  assign new_game     = new_game_q;
  assign menu_enable  = (state_q == ST_MENU) && armed_q;
  assign board_enable = (state_q == ST_GAME) && armed_q;
  assign end_enable   = (state_q == ST_END)  && armed_q;

endmodule

// File: tb/tb_screen_ctl.sv
// ---------------------------------------------------------------------------
// tb_screen_ctl
// Directed self-checking bench for screen_ctl with a small reference model.
// ---------------------------------------------------------------------------
module tb_screen_ctl;
  import screen_ctl_pkg::*;

  localparam int HOLD = 4;
  localparam int FREQ = 10;
  localparam int MAXS = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             mouse_left;
  logic             start_pressed;
  logic             again_pressed;
  logic             board_done;
  logic             menu_enable;
  logic             board_enable;
  logic             end_enable;
  logic             new_game;
  logic [1:0]       screen;
  logic [SEC_W-1:0] elapsed_sec;

  int checks = 0;
  int errors = 0;

  // Reference model state: screen code, arming, edges since entering the
  // current screen, pending pulse, and clock ticks spent in GAME.
  bit modelValid = 0;
  int mScreen;
  bit mArmed;
  int mSince;
  bit mNew;
  int mTicks;
  int mSec;

  screen_ctl #(
    .CLK_FREQ       (FREQ),
    .HOLDOFF_CYCLES (HOLD),
    .MAX_SEC        (MAXS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mouse_left    (mouse_left),
    .start_pressed (start_pressed),
    .again_pressed (again_pressed),
    .board_done    (board_done),
    .menu_enable   (menu_enable),
    .board_enable  (board_enable),
    .end_enable    (end_enable),
    .new_game      (new_game),
    .screen        (screen),
    .elapsed_sec   (elapsed_sec)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit ag, input bit dn, input bit ms);
    start_pressed = st;
    again_pressed = ag;
    board_done    = dn;
    mouse_left    = ms;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Model update: works from the rules directly. Seconds are the GAME tick
  // count divided by the clock rate, capped; arming happens on any edge with
  // the mouse up that lies beyond the holdoff window after screen entry.
  always @(posedge clk) begin
    int  nextScreen;
    bit  pulse;
    bit  wasGame;
    if (rst) begin
      modelValid = 1;
      mScreen    = 0;
      mArmed     = 0;
      mSince     = 0;
      mNew       = 0;
      mTicks     = 0;
      mSec       = 0;
    end else begin
      nextScreen = mScreen;
      pulse      = 0;
      wasGame    = (mScreen == 1);
      if (mScreen == 0 && mArmed && start_pressed) begin
        nextScreen = 1;
        pulse      = 1;
      end else if (mScreen == 1 && board_done) begin
        nextScreen = 2;
      end else if (mScreen == 2 && mArmed && again_pressed) begin
        nextScreen = 1;
        pulse      = 1;
      end
      if (pulse) begin
        mTicks = 0;
      end else if (wasGame) begin
        mTicks++;
      end
      mSec = (mTicks / FREQ > MAXS) ? MAXS : mTicks / FREQ;
      if (nextScreen != mScreen) begin
        mArmed = 0;
        mSince = 0;
      end else begin
        mSince++;
        if (mSince >= HOLD + 1 && !mouse_left) mArmed = 1;
      end
      mScreen = nextScreen;
      mNew    = pulse;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("screen", int'(screen), mScreen);
      checkOutput("menu_enable", int'(menu_enable), int'(mScreen == 0 && mArmed));
      checkOutput("board_enable", int'(board_enable), int'(mScreen == 1 && mArmed));
      checkOutput("end_enable", int'(end_enable), int'(mScreen == 2 && mArmed));
      checkOutput("new_game", int'(new_game), int'(mNew));
      checkOutput("elapsed_sec", int'(elapsed_sec), mSec);
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);
    step(2);
    rst = 1'b0;
    checkOutput("rst_screen", int'(screen), 0);
    checkOutput("rst_menu_en", int'(menu_enable), 0);
    checkOutput("rst_elapsed", int'(elapsed_sec), 0);
    checkOutput("rst_new_game", int'(new_game), 0);

    // Start during holdoff is ignored; menu enable rises at edge 5.
    step(2);
    applyStimulus(1, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("holdoff_start_ignored", int'(screen), 0);
    step(1);
    checkOutput("menu_en_edge4", int'(menu_enable), 0);
    step(1);
    checkOutput("menu_en_edge5", int'(menu_enable), 1);

    // Start click with the mouse held for 20 cycles.
    applyStimulus(1, 0, 0, 1);
    step(1);
    checkOutput("start_screen", int'(screen), 1);
    checkOutput("start_new_game", int'(new_game), 1);
    checkOutput("start_menu_en_drop", int'(menu_enable), 0);
    checkOutput("start_elapsed", int'(elapsed_sec), 0);
    applyStimulus(0, 0, 0, 1);
    step(1);
    checkOutput("new_game_one_cycle", int'(new_game), 0);
    step(18);
    checkOutput("board_en_mouse_held", int'(board_enable), 0);
    applyStimulus(0, 0, 0, 0);
    step(1);
    checkOutput("board_en_after_release", int'(board_enable), 1);

    // Play-again strobe in GAME is ignored.
    applyStimulus(0, 1, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("again_in_game_screen", int'(screen), 1);
    checkOutput("again_in_game_pulse", int'(new_game), 0);
    step(14);
    checkOutput("elapsed_35_cycles", int'(elapsed_sec), 3);

    // Board done: END on the same edge, time frozen.
    applyStimulus(0, 0, 1, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("done_screen", int'(screen), 2);
    checkOutput("done_board_en_drop", int'(board_enable), 0);
    step(100);
    checkOutput("end_elapsed_frozen", int'(elapsed_sec), 3);
    checkOutput("end_en_armed", int'(end_enable), 1);

    // Start strobe in END is ignored.
    applyStimulus(1, 0, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("start_in_end", int'(screen), 2);

    // Play again clears the timer with the pulse.
    applyStimulus(0, 1, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("again_screen", int'(screen), 1);
    checkOutput("again_new_game", int'(new_game), 1);
    checkOutput("again_elapsed", int'(elapsed_sec), 0);
    step(5);
    checkOutput("board_en_rearmed", int'(board_enable), 1);

    // Board done together with a start strobe goes to END.
    applyStimulus(1, 0, 1, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("priority_screen", int'(screen), 2);
    checkOutput("priority_no_pulse", int'(new_game), 0);

    // Saturation after 80 cycles in GAME.
    step(5);
    applyStimulus(0, 1, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    step(80);
    checkOutput("elapsed_saturated", int'(elapsed_sec), 5);

    // Reset mid-GAME with two seconds on the clock.
    applyStimulus(0, 0, 1, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    step(5);
    applyStimulus(0, 1, 0, 0);
    step(1);
    applyStimulus(0, 0, 0, 0);
    step(25);
    checkOutput("elapsed_before_reset", int'(elapsed_sec), 2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    checkOutput("midrst_screen", int'(screen), 0);
    checkOutput("midrst_board_en", int'(board_enable), 0);
    checkOutput("midrst_menu_en", int'(menu_enable), 0);
    checkOutput("midrst_elapsed", int'(elapsed_sec), 0);
    checkOutput("midrst_new_game", int'(new_game), 0);
    step(5);
    checkOutput("midrst_menu_rearm", int'(menu_enable), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
